// File: rtl/sram_sp_be_arbiter.sv
// ---------------------------------------------------------------------------
// sram_sp_be_arbiter
//
// Shares one single-port SRAM with byte/column write enables between two
// requesters (A and B). Each cycle at most one access is granted, either a
// read (wen all zero) or a column-masked write. Arbitration is round-robin,
// and a requester may hold ownership across a locked burst of at most
// MAX_BURST grants. Read data comes back one cycle after the granted read and
// is steered to the requester that issued it.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   a_req/a_lck/a_adr/a_wen/a_wdat  port A request, lock, address, column
//                                   write enables (0 = read), write data
//   a_gnt                          port A access accepted this cycle
//   a_rvld/a_rdat                  port A read data valid / data (0 if idle)
//   b_*                            same set for port B
//   sram_adr/sram_wr_ena/sram_wr_dat/sram_rd_ena  SRAM controls
//   sram_rd_dat                    SRAM read data, valid cycle after rd_ena
// ---------------------------------------------------------------------------
module sram_sp_be_arbiter #(
    parameter int ADR_WD    = 5,
    parameter int DAT_WD    = 8,
    parameter int COL_WD    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_req,
    input  logic                       a_lck,
    input  logic [ADR_WD-1:0]          a_adr,
    input  logic [DAT_WD/COL_WD-1:0]   a_wen,
    input  logic [DAT_WD-1:0]          a_wdat,
    output logic                       a_gnt,
    output logic                       a_rvld,
    output logic [DAT_WD-1:0]          a_rdat,
    input  logic                       b_req,
    input  logic                       b_lck,
    input  logic [ADR_WD-1:0]          b_adr,
    input  logic [DAT_WD/COL_WD-1:0]   b_wen,
    input  logic [DAT_WD-1:0]          b_wdat,
    output logic                       b_gnt,
    output logic                       b_rvld,
    output logic [DAT_WD-1:0]          b_rdat,
    output logic [ADR_WD-1:0]          sram_adr,
    output logic [DAT_WD/COL_WD-1:0]   sram_wr_ena,
    output logic [DAT_WD-1:0]          sram_wr_dat,
    output logic                       sram_rd_ena,
    input  logic [DAT_WD-1:0]          sram_rd_dat
);

    localparam int   EN_WD  = DAT_WD / COL_WD;
    localparam int   CNT_WD = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } state_t;

    state_t            state, state_nxt;
    logic              last_gnt, last_nxt;
    logic [CNT_WD-1:0] burst_cnt, cnt_nxt;
    logic              a_rvld_q, b_rvld_q;
    logic              pick_a, pick_b;
    int                cnt_plus;
    logic              a_rd, b_rd;

    // State register: ownership, round-robin pointer, burst counter and the
    // one-cycle read-valid flags. Reset makes B the last winner so A takes
    // the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= LAST_B;
            burst_cnt <= '0;
            a_rvld_q  <= 1'b0;
            b_rvld_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_gnt  <= last_nxt;
            burst_cnt <= cnt_nxt;
            a_rvld_q  <= a_rd;
            b_rvld_q  <= b_rd;
        end
    end

    // Grant and next-state logic. An owner that is still requesting keeps the
    // SRAM until it drops the lock or its burst hits MAX_BURST grants. An
    // owner that stops requesting gives up the hold immediately, so this
    // cycle is arbitrated exactly like IDLE.
    always_comb begin
        state_nxt = state;
        last_nxt  = last_gnt;
        cnt_nxt   = burst_cnt;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        pick_a    = 1'b0;
        pick_b    = 1'b0;
        cnt_plus  = int'(burst_cnt) + 1;
        if (!rst) begin
            if (state == OWN_A && a_req) begin
                a_gnt = 1'b1;
                if (a_lck && cnt_plus < MAX_BURST) begin
                    state_nxt = OWN_A;
                    cnt_nxt   = CNT_WD'(cnt_plus);
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end else if (state == OWN_B && b_req) begin
                b_gnt = 1'b1;
                if (b_lck && cnt_plus < MAX_BURST) begin
                    state_nxt = OWN_B;
                    cnt_nxt   = CNT_WD'(cnt_plus);
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end else begin
                pick_a    = a_req && (!b_req || last_gnt == LAST_B);
                pick_b    = b_req && !pick_a;
                state_nxt = IDLE;
                cnt_nxt   = '0;
                if (pick_a) begin
                    a_gnt = 1'b1;
                    if (a_lck && MAX_BURST > 1) begin
                        state_nxt = OWN_A;
                        cnt_nxt   = CNT_WD'(1);
                    end
                end else if (pick_b) begin
                    b_gnt = 1'b1;
                    if (b_lck && MAX_BURST > 1) begin
                        state_nxt = OWN_B;
                        cnt_nxt   = CNT_WD'(1);
                    end
                end
            end
            if (a_gnt) begin
                last_nxt = LAST_A;
            end else if (b_gnt) begin
                last_nxt = LAST_B;
            end
        end
    end

    // SRAM-side mux: the granted port drives everything, and with no grant
    // every control and data line is held at zero.
    assign a_rd        = a_gnt && (a_wen == '0);
    assign b_rd        = b_gnt && (b_wen == '0);
    assign sram_rd_ena = a_rd || b_rd;
    assign sram_adr    = a_gnt ? a_adr  : (b_gnt ? b_adr  : '0);
    assign sram_wr_dat = a_gnt ? a_wdat : (b_gnt ? b_wdat : '0);
    assign sram_wr_ena = a_gnt ? a_wen  : (b_gnt ? b_wen  : {EN_WD{1'b0}});

    // Return path: the SRAM data lands one cycle after the read and goes to
    // whichever port's read-valid flag is set; the other port sees zero.
    assign a_rvld = a_rvld_q;
    assign b_rvld = b_rvld_q;
    assign a_rdat = a_rvld_q ? sram_rd_dat : '0;
    assign b_rdat = b_rvld_q ? sram_rd_dat : '0;

endmodule

// File: tb/tb_sram_sp_be_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_sp_be_arbiter
//
// Bench for sram_sp_be_arbiter with a 16-bit, two-column SRAM model. Every
// read the bench expects to be granted pushes its expected data onto a
// scoreboard; a monitor pops it when the read data is due.
// ---------------------------------------------------------------------------
module tb_sram_sp_be_arbiter;

    localparam int ADR_WD    = 5;
    localparam int DAT_WD    = 16;
    localparam int COL_WD    = 8;
    localparam int EN_WD     = DAT_WD / COL_WD;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_req, a_lck, b_req, b_lck;
    logic [ADR_WD-1:0] a_adr, b_adr;
    logic [EN_WD-1:0]  a_wen, b_wen;
    logic [DAT_WD-1:0] a_wdat, b_wdat;
    logic              a_gnt, b_gnt, a_rvld, b_rvld;
    logic [DAT_WD-1:0] a_rdat, b_rdat;
    logic [ADR_WD-1:0] sram_adr;
    logic [EN_WD-1:0]  sram_wr_ena;
    logic [DAT_WD-1:0] sram_wr_dat;
    logic              sram_rd_ena;
    logic [DAT_WD-1:0] sram_rd_dat;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        bit          port;
        logic [15:0] dat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] mem    [32];
    logic [15:0] shadow [32];

    sram_sp_be_arbiter #(
        .ADR_WD(ADR_WD), .DAT_WD(DAT_WD), .COL_WD(COL_WD), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_lck(a_lck), .a_adr(a_adr), .a_wen(a_wen), .a_wdat(a_wdat),
        .a_gnt(a_gnt), .a_rvld(a_rvld), .a_rdat(a_rdat),
        .b_req(b_req), .b_lck(b_lck), .b_adr(b_adr), .b_wen(b_wen), .b_wdat(b_wdat),
        .b_gnt(b_gnt), .b_rvld(b_rvld), .b_rdat(b_rdat),
        .sram_adr(sram_adr), .sram_wr_ena(sram_wr_ena), .sram_wr_dat(sram_wr_dat),
        .sram_rd_ena(sram_rd_ena), .sram_rd_dat(sram_rd_dat)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp scoreboard entries.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: registered read, zero when not reading, column writes.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            sram_rd_dat <= '0;
        end else begin
            sram_rd_dat <= sram_rd_ena ? mem[sram_adr] : '0;
            for (int c = 0; c < EN_WD; c++)
                if (sram_wr_ena[c]) mem[sram_adr][c*COL_WD +: COL_WD] <= sram_wr_dat[c*COL_WD +: COL_WD];
        end
    end

    // Read-return monitor: when an entry is due, only its port may be valid
    // with the expected data; otherwise both ports must be idle and zero.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (a_rvld !== (mon_e.port == 1'b0) || b_rvld !== (mon_e.port == 1'b1)) begin
                n_fail++;
                $display("[TB] FAIL sb_rvld cyc %0d: got a=%b b=%b want port %0d", cyc, a_rvld, b_rvld, mon_e.port);
            end
            n_checks++;
            if ((mon_e.port ? b_rdat : a_rdat) !== mon_e.dat) begin
                n_fail++;
                $display("[TB] FAIL sb_rdat cyc %0d: got %h want %h", cyc, mon_e.port ? b_rdat : a_rdat, mon_e.dat);
            end
        end else begin
            n_checks++;
            if (a_rvld !== 1'b0 || b_rvld !== 1'b0 || a_rdat !== '0 || b_rdat !== '0) begin
                n_fail++;
                $display("[TB] FAIL sb_idle cyc %0d: got rvld a=%b b=%b rdat a=%h b=%h want all 0",
                         cyc, a_rvld, b_rvld, a_rdat, b_rdat);
            end
        end
    end

    task automatic set_a(input logic req, input logic lck, input logic [ADR_WD-1:0] adr,
                         input logic [EN_WD-1:0] wen, input logic [DAT_WD-1:0] wdat);
        a_req = req; a_lck = lck; a_adr = adr; a_wen = wen; a_wdat = wdat;
    endtask

    task automatic set_b(input logic req, input logic lck, input logic [ADR_WD-1:0] adr,
                         input logic [EN_WD-1:0] wen, input logic [DAT_WD-1:0] wdat);
        b_req = req; b_lck = lck; b_adr = adr; b_wen = wen; b_wdat = wdat;
    endtask

    // Model of an access the bench expects to be granted this cycle.
    task automatic model_access(input bit port, input logic [ADR_WD-1:0] adr,
                                input logic [EN_WD-1:0] wen, input logic [DAT_WD-1:0] wdat);
        exp_t e;
        if (wen == '0) begin
            e.cyc  = cyc + 1;
            e.port = port;
            e.dat  = shadow[adr];
            sb.push_back(e);
        end else begin
            for (int c = 0; c < EN_WD; c++)
                if (wen[c]) shadow[adr][c*COL_WD +: COL_WD] = wdat[c*COL_WD +: COL_WD];
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_a(1'b1, 1'b0, 5'd1, 2'b00, 16'h0);
        set_b(1'b1, 1'b0, 5'd2, 2'b00, 16'h0);
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_gnt: got a=%b b=%b want 0 0", a_gnt, b_gnt);
            end
            n_checks++;
            if (sram_rd_ena !== 1'b0 || sram_wr_ena !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL reset_sram: got rd=%b wr=%b want 0 00", sram_rd_ena, sram_wr_ena);
            end
            next_cycle();
        end
        rst = 1'b0;
        set_a(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
        set_b(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
        @(negedge clk);
        n_checks++;
        if (a_rvld !== 1'b0 || b_rvld !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_rvld: got a=%b b=%b want 0 0", a_rvld, b_rvld);
        end
        next_cycle();
    endtask

    task automatic test_single();
        set_a(1'b1, 1'b0, 5'd3, 2'b01, 16'h005A);
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_wr_gnt: got a=%b b=%b want 1 0", a_gnt, b_gnt);
        end
        n_checks++;
        if (sram_wr_ena !== 2'b01 || sram_adr !== 5'd3 || sram_rd_ena !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_wr_sram: got wr=%b adr=%0d rd=%b want 01 3 0", sram_wr_ena, sram_adr, sram_rd_ena);
        end
        model_access(1'b0, 5'd3, 2'b01, 16'h005A);
        next_cycle();
        set_a(1'b1, 1'b0, 5'd3, 2'b00, 16'h0);
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1 || sram_rd_ena !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_rd_gnt: got gnt=%b rd=%b want 1 1", a_gnt, sram_rd_ena);
        end
        model_access(1'b0, 5'd3, 2'b00, 16'h0);
        next_cycle();
        set_a(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
        @(negedge clk);
        n_checks++;
        if (a_rvld !== 1'b1 || a_rdat !== 16'h005A) begin
            n_fail++;
            $display("[TB] FAIL single_rdat: got rvld=%b dat=%h want 1 005a", a_rvld, a_rdat);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        set_a(1'b1, 1'b0, 5'd1, 2'b11, 16'h1111);
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rr_prewrite_a: got %b want 1", a_gnt);
        end
        model_access(1'b0, 5'd1, 2'b11, 16'h1111);
        next_cycle();
        set_a(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
        set_b(1'b1, 1'b0, 5'd2, 2'b11, 16'h2222);
        @(negedge clk);
        n_checks++;
        if (b_gnt !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rr_prewrite_b: got %b want 1", b_gnt);
        end
        model_access(1'b1, 5'd2, 2'b11, 16'h2222);
        next_cycle();
        set_a(1'b1, 1'b0, 5'd1, 2'b00, 16'h0);
        set_b(1'b1, 1'b0, 5'd2, 2'b00, 16'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin
                n_fail++;
                $display("[TB] FAIL rr_gnt[%0d]: got a=%b b=%b want a=%b", i, a_gnt, b_gnt, (i % 2 == 0));
            end
            if (i % 2 == 0) model_access(1'b0, 5'd1, 2'b00, 16'h0);
            else            model_access(1'b1, 5'd2, 2'b00, 16'h0);
            next_cycle();
        end
        set_a(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
        set_b(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
    endtask

    task automatic test_burst();
        int b_wait   = 0;
        int max_wait = 0;
        set_a(1'b1, 1'b1, 5'd1, 2'b00, 16'h0);
        set_b(1'b1, 1'b0, 5'd2, 2'b00, 16'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_gnt !== (i != 4) || b_gnt !== (i == 4)) begin
                n_fail++;
                $display("[TB] FAIL burst_gnt[%0d]: got a=%b b=%b want a=%b", i, a_gnt, b_gnt, (i != 4));
            end
            if (i != 4) model_access(1'b0, 5'd1, 2'b00, 16'h0);
            else        model_access(1'b1, 5'd2, 2'b00, 16'h0);
            if (b_gnt === 1'b1) begin
                if (b_wait > max_wait) max_wait = b_wait;
                b_wait = 0;
            end else begin
                b_wait++;
            end
            next_cycle();
        end
        n_checks++;
        if (max_wait > MAX_BURST || b_wait > MAX_BURST) begin
            n_fail++;
            $display("[TB] FAIL burst_starve: got wait %0d want <= %0d", (max_wait > b_wait) ? max_wait : b_wait, MAX_BURST);
        end
        set_a(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL burst_owner_drop: got a=%b b=%b want 0 1", a_gnt, b_gnt);
        end
        model_access(1'b1, 5'd2, 2'b00, 16'h0);
        next_cycle();
        set_b(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
    endtask

    task automatic test_column_mask();
        set_a(1'b1, 1'b0, 5'd7, 2'b11, 16'hFFFF);
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1 || sram_wr_ena !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL col_wr_full: got gnt=%b wr=%b want 1 11", a_gnt, sram_wr_ena);
        end
        model_access(1'b0, 5'd7, 2'b11, 16'hFFFF);
        next_cycle();
        set_a(1'b1, 1'b0, 5'd7, 2'b01, 16'h1234);
        @(negedge clk);
        n_checks++;
        if (sram_wr_ena !== 2'b01 || sram_wr_dat !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL col_wr_mask: got wr=%b dat=%h want 01 1234", sram_wr_ena, sram_wr_dat);
        end
        model_access(1'b0, 5'd7, 2'b01, 16'h1234);
        next_cycle();
        set_a(1'b1, 1'b0, 5'd7, 2'b00, 16'h0);
        @(negedge clk);
        n_checks++;
        if (sram_rd_ena !== 1'b1 || sram_wr_ena !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL col_rd: got rd=%b wr=%b want 1 00", sram_rd_ena, sram_wr_ena);
        end
        model_access(1'b0, 5'd7, 2'b00, 16'h0);
        next_cycle();
        set_a(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
        @(negedge clk);
        n_checks++;
        if (a_rvld !== 1'b1 || a_rdat !== 16'hFF34) begin
            n_fail++;
            $display("[TB] FAIL col_rdat: got rvld=%b dat=%h want 1 ff34", a_rvld, a_rdat);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        set_a(1'b1, 1'b1, 5'd9, 2'b11, 16'hABCD);
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rmb_gnt0: got %b want 1", a_gnt);
        end
        model_access(1'b0, 5'd9, 2'b11, 16'hABCD);
        next_cycle();
        set_a(1'b1, 1'b1, 5'd10, 2'b11, 16'h5555);
        set_b(1'b1, 1'b0, 5'd1, 2'b00, 16'h0);
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rmb_gnt1: got a=%b b=%b want 1 0", a_gnt, b_gnt);
        end
        model_access(1'b0, 5'd10, 2'b11, 16'h5555);
        next_cycle();
        rst = 1'b1;
        set_a(1'b1, 1'b1, 5'd7, 2'b00, 16'h0);
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || sram_rd_ena !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rmb_rst_gnt: got a=%b b=%b rd=%b want 0 0 0", a_gnt, b_gnt, sram_rd_ena);
        end
        n_checks++;
        if (a_rvld !== 1'b0 || b_rvld !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rmb_rst_rvld: got a=%b b=%b want 0 0", a_rvld, b_rvld);
        end
        next_cycle();
        rst = 1'b0;
        set_a(1'b1, 1'b0, 5'd7, 2'b00, 16'h0);
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rmb_tie: got a=%b b=%b want 1 0", a_gnt, b_gnt);
        end
        model_access(1'b0, 5'd7, 2'b00, 16'h0);
        next_cycle();
        set_a(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
        @(negedge clk);
        n_checks++;
        if (b_gnt !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rmb_b_after: got %b want 1", b_gnt);
        end
        model_access(1'b1, 5'd1, 2'b00, 16'h0);
        next_cycle();
        set_b(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        set_a(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
        set_b(1'b0, 1'b0, 5'd0, 2'b00, 16'h0);
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        next_cycle();
        $display("[TB] reset");
        test_reset();
        $display("[TB] single port");
        test_single();
        $display("[TB] round robin");
        test_round_robin();
        $display("[TB] burst limit");
        test_burst();
        $display("[TB] column mask");
        test_column_mask();
        $display("[TB] reset mid-burst");
        test_reset_mid_burst();
        repeat (3) next_cycle();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL sb_drain: got %0d pending reads want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
